i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Transmit-side counterpart of the mic_load serial receiver: serialises stereo PCM words onto AUD_DACDAT for the WM8731 DAC.
- Codec is bus master: it drives AUD_BCLK (3.072 MHz) and AUD_DACLRCK (96 kHz frame, 16 BCLKs per channel).
- The block oversamples both clocks from a single fast system clock.
- A small FIFO with valid/ready upstream decouples audio producers (tone/beat generators, loopback) from the codec frame timing.

Parameters:
- N, 16, sample width in bits per channel.
- DEPTH, 4, FIFO depth in stereo frames; power of two, at least 2.
- SLOT_BITS, 16, BCLK periods per channel slot; must be at least N.

Ports:
- clk  in  1  system clock, CLOCK_50 (must be at least 16x bclk).
- reset  in  1  synchronous, active-high.
- bclk  in  1  codec bit clock (AUD_BCLK), asynchronous to clk.
- daclrck  in  1  codec DAC frame clock (AUD_DACLRCK), asynchronous; 1 = left, 0 = right.
- sample_left  in  N  left PCM word, two's complement.
- sample_right  in  N  right PCM word, two's complement.
- sample_valid  in  1  upstream word pair valid.
- sample_ready  out  1  FIFO not full.
- dacdat  out  1  serial data to AUD_DACDAT.
- underrun  out  1  one-clk pulse when a left slot starts with the FIFO empty.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- **Synchronisation**
  - bclk and daclrck each pass through a 2-flop synchroniser, then a third flop for edge detection.
  - Fall event = synced bclk goes 1 to 0.
- **Format: left-justified, MSB first**
  - Data changes only on fall events; the codec samples on BCLK rise.
  - The MSB is valid after the first fall event following a daclrck transition.
- **Output timing**
  - dacdat is registered.
  - Change occurs 4 clk cycles at most after the physical BCLK falling edge, which is under half a BCLK period at 50 MHz.
- **Handshake**
  - Push when sample_valid && sample_ready.
  - sample_ready = (level != DEPTH), combinational from level.
  - Push and pop in the same clk cycle are both allowed; level is unchanged.
- **FSM states: IDLE, LEFT, RIGHT**
  - IDLE: dacdat = 0. Stay until a fall event where synced daclrck = 1 and the previous latched lrck = 0 (frame start).
  - Frame start, from IDLE or RIGHT:
    - If FIFO is non-empty: pop; load shift_l <= sample_left and shift_r <= sample_right.
    - If FIFO is empty: load zeros and pulse underrun for 1 clk.
    - Set bit_cnt = 0, drive dacdat = MSB of shift_l, go to LEFT.
  - LEFT: each later fall event shifts left and increments bit_cnt.
    - For bit_cnt >= N, dacdat = 0 (slot padding).
    - bit_cnt saturates at SLOT_BITS-1.
  - daclrck 1->0 seen at a fall event: drive MSB of shift_r, bit_cnt = 0, go to RIGHT. Same shifting and padding rules apply.
  - RIGHT to LEFT only through a frame start (pop).
  - A daclrck edge seen while bit_cnt < N-1 (short slot) aborts the current word and follows the edge anyway. No error is flagged.
- **FIFO**
  - Circular buffer; pointers wrap modulo DEPTH.
  - Pushes while full are impossible because ready is low.
  - A pop is issued only at frame start and only if level > 0.
- **Reset**
  - Takes effect at any point, including mid-slot.
  - dacdat = 0, underrun = 0, level = 0, pointers = 0, shift registers = 0, FSM = IDLE, synchroniser flops = 0.
  - After reset the block never emits a partial frame: it waits in IDLE for the next frame start.
- **Reset values of outputs**: sample_ready = 1 (level = 0), dacdat = 0, underrun = 0, fifo_level = 0.

Optional Feature:
- Macro I2S_DAC_TX_HOLD_EN.
- Defined: on underrun, the frame reuses the last popped left/right pair (zero after reset), and underrun still pulses.
- Undefined: underrun frames transmit zeros.

Decomposition:
- Package audio_pkg holds:
  - typedef stereo_t {logic [N-1:0] left, right}, with N fixed at 16 in the package.
  - enum tx_state_e {IDLE, LEFT, RIGHT}.
  - localparam SLOT_BITS_DEFAULT = 16.
- One sub-module: sample_fifo, a parameterised synchronous FIFO with push/pop/level and full/empty flags.
- Synchroniser and edge detect stay inline.

Test Plan:
- Model the codec as master: bclk 3.072 MHz, daclrck 96 kHz, clk 50 MHz.
- **Single frame**: push L=16'hA5C3, R=16'h0F0F, then let one frame elapse.
  - The bench samples dacdat on bclk rise: left slot = A5C3 MSB first, right slot = 0F0F.
  - underrun stays 0; fifo_level goes 1 -> 0 at the left start.
- **Fill/back-pressure**: push 5 pairs back-to-back with DEPTH=4.
  - sample_ready drops after the 4th; the 5th is held until the first frame start pops.
  - Frames arrive in push order.
- **Underrun**: empty FIFO at a frame start.
  - Without the macro: 32 zero bits and a single-clk underrun pulse.
  - With I2S_DAC_TX_HOLD_EN: the previous pair 1234/5678 is repeated.
- **Reset mid-left-slot after 7 bits**:
  - dacdat = 0 and level = 0 on the next clk.
  - No bits are emitted until the following daclrck rise; the next frame is complete.
- **Simultaneous push and pop**: with level = 2, assert valid on the same clk as the frame-start pop.
  - Level stays 2 and the data order is preserved.
- **SLOT_BITS=24, N=16**: each slot carries 16 data bits followed by 8 zero bits.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio transmit path.
//   STEREO_N          : sample width carried by stereo_t
//   SLOT_BITS_DEFAULT : BCLK periods per channel slot for a 96 kHz / 16-bit frame
//   stereo_t          : one left/right PCM pair
//   tx_state_e        : serialiser state (IDLE, LEFT, RIGHT)
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int STEREO_N          = 16;
    localparam int SLOT_BITS_DEFAULT = 16;

    typedef struct packed {
        logic [STEREO_N-1:0] left;
        logic [STEREO_N-1:0] right;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous circular-buffer FIFO. Pushes while full and pops while empty are
// ignored. Read data is the head entry, valid whenever empty is low.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, wdata     : write request and data
//   pop             : remove head entry
//   rdata           : head entry
//   level           : occupancy, 0..DEPTH
//   full, empty     : occupancy flags
// DEPTH must be a power of two (pointers wrap by overflow), at least 2.
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
// Left-justified, MSB-first serialiser for the WM8731 DAC with the codec as
// bus master. BCLK and DACLRCK are oversampled on clk; a small FIFO decouples
// upstream producers from frame timing.
// Ports:
//   clk, reset                  : system clock, synchronous active-high reset
//   bclk, daclrck               : codec bit / frame clocks (asynchronous)
//   sample_left/right/valid     : upstream stereo word pair, pushed when ready
//   sample_ready                : FIFO not full
//   dacdat                      : registered serial data to AUD_DACDAT
//   underrun                    : one-clk pulse, left slot started with FIFO empty
//   fifo_level                  : FIFO occupancy
// Build option:
//   I2S_DAC_TX_HOLD_EN defined  : underrun frames repeat the last popped pair
//   undefined                   : underrun frames transmit zeros
//
// state | meaning
// IDLE  | waiting for a frame start, dacdat held low
// LEFT  | shifting left word, zero padding after N bits
// RIGHT | shifting right word, zero padding after N bits
// -----------------------------------------------------------------------------
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int N         = 16,
    parameter int DEPTH     = 4,
    parameter int SLOT_BITS = SLOT_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bclk,
    input  logic                   daclrck,
    input  logic [N-1:0]           sample_left,
    input  logic [N-1:0]           sample_right,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   dacdat,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] fifo_level
);

    // Counter wide enough to hold both SLOT_BITS-1 and N for the padding compare.
    localparam int             CW      = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0]  N_C     = CW'(N);

    logic [2:0]      bclk_sync_q;
    logic [1:0]      lrck_sync_q;
    logic            lrck_prev_q;
    logic            lrck_valid_q;
    tx_state_e       state_q;
    logic [N-1:0]    shift_l_q;
    logic [N-1:0]    shift_r_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [CW-1:0]   bit_cnt_d;
    logic            dacdat_q;
    logic            underrun_q;

    logic            fall_evt;
    logic            lrck_now;
    logic            frame_start;
    logic            right_start;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2*N-1:0]  fifo_rdata;
    logic [N-1:0]    load_l;
    logic [N-1:0]    load_r;

    // Two flops to synchronise, a third (bclk) for edge detection. The lrck
    // edge is detected against lrck_prev_q, which is latched only on fall events.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], bclk};
            lrck_sync_q <= {lrck_sync_q[0], daclrck};
        end
    end

    assign fall_evt = bclk_sync_q[2] && !bclk_sync_q[1];
    assign lrck_now = lrck_sync_q[1];

    // lrck_valid_q blocks edge decisions until one lrck value has been latched
    // after reset, so a reset in mid-left-slot cannot be mistaken for a frame start.
    assign frame_start = fall_evt && lrck_valid_q && lrck_now && !lrck_prev_q;
    assign right_start = fall_evt && lrck_valid_q && !lrck_now && lrck_prev_q
                         && (state_q != IDLE);

    sample_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid),
        .pop   (frame_start && !fifo_empty),
        .wdata ({sample_left, sample_right}),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef I2S_DAC_TX_HOLD_EN
    logic [2*N-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (frame_start && !fifo_empty) begin
            hold_q <= fifo_rdata;
        end
    end

    assign {load_l, load_r} = fifo_empty ? hold_q : fifo_rdata;
`else
    assign {load_l, load_r} = fifo_empty ? '0 : fifo_rdata;
`endif

    assign bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CW'(1);

    // Shift registers rotate rather than shift; bits past N are masked by the
    // counter compare, so what rotates back in is never driven out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lrck_prev_q  <= 1'b0;
            lrck_valid_q <= 1'b0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
            bit_cnt_q    <= '0;
            dacdat_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (fall_evt) begin
                lrck_prev_q  <= lrck_now;
                lrck_valid_q <= 1'b1;
            end
            if (frame_start) begin
                shift_l_q  <= load_l;
                shift_r_q  <= load_r;
                bit_cnt_q  <= '0;
                dacdat_q   <= load_l[N-1];
                underrun_q <= fifo_empty;
                state_q    <= LEFT;
            end else if (right_start) begin
                bit_cnt_q <= '0;
                dacdat_q  <= shift_r_q[N-1];
                state_q   <= RIGHT;
            end else if (fall_evt) begin
                case (state_q)
                    LEFT: begin
                        shift_l_q <= {shift_l_q[N-2:0], shift_l_q[N-1]};
                        bit_cnt_q <= bit_cnt_d;
                        dacdat_q  <= (bit_cnt_d < N_C) ? shift_l_q[N-2] : 1'b0;
                    end
                    RIGHT: begin
                        shift_r_q <= {shift_r_q[N-2:0], shift_r_q[N-1]};
                        bit_cnt_q <= bit_cnt_d;
                        dacdat_q  <= (bit_cnt_d < N_C) ? shift_r_q[N-2] : 1'b0;
                    end
                    default: begin
                        dacdat_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample_ready = !fifo_full;
    assign dacdat       = dacdat_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
`timescale 1ns/1ps
module tb_i2s_dac_tx;

    localparam real BH  = 162.761;   // half BCLK period, ~3.072 MHz
    localparam int  LIM = 3000;

`ifdef I2S_DAC_TX_HOLD_EN
    localparam logic [31:0] UNDER_EXP = 32'h1234_5678;
`else
    localparam logic [31:0] UNDER_EXP = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bclk = 1'b0;
    logic        lrck16 = 1'b0;
    logic        lrck24 = 1'b0;
    int          idx16 = 31;
    int          idx24 = 47;

    logic [15:0] sample_left = '0;
    logic [15:0] sample_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        dacdat;
    logic        underrun;
    logic [2:0]  fifo_level;

    logic [15:0] left24 = '0;
    logic [15:0] right24 = '0;
    logic        valid24 = 1'b0;
    logic        ready24;
    logic        dacdat24;
    logic        underrun24;
    logic [2:0]  level24;

    logic [31:0] cap16_cur = '0;
    logic [31:0] cap16 = '0;
    logic [47:0] cap24_cur = '0;
    logic [47:0] cap24 = '0;
    int          frames16 = 0;
    int          frames24 = 0;
    int          ur_cnt = 0;
    int          ur_long = 0;
    logic        ur_prev = 1'b0;
    logic [2:0]  bsync_m = '0;

    int          checks = 0;
    int          errors = 0;

    i2s_dac_tx #(.N(16), .DEPTH(4), .SLOT_BITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .daclrck      (lrck16),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dacdat       (dacdat),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    i2s_dac_tx #(.N(16), .DEPTH(4), .SLOT_BITS(24)) dut24 (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .daclrck      (lrck24),
        .sample_left  (left24),
        .sample_right (right24),
        .sample_valid (valid24),
        .sample_ready (ready24),
        .dacdat       (dacdat24),
        .underrun     (underrun24),
        .fifo_level   (level24)
    );

    always #10 clk = ~clk;

    // Codec master: lrck changes together with the falling bclk edge.
    always begin
        #(BH) bclk = 1'b1;
        #(BH);
        idx16  = (idx16 == 31) ? 0 : idx16 + 1;
        lrck16 = (idx16 < 16);
        idx24  = (idx24 == 47) ? 0 : idx24 + 1;
        lrck24 = (idx24 < 24);
        bclk   = 1'b0;
    end

    // Codec sampling on bclk rise, one frame word per capture.
    always @(posedge bclk) begin
        cap16_cur[31 - idx16] = dacdat;
        if (idx16 == 31) begin
            cap16    = cap16_cur;
            frames16 = frames16 + 1;
        end
        cap24_cur[47 - idx24] = dacdat24;
        if (idx24 == 47) begin
            cap24    = cap24_cur;
            frames24 = frames24 + 1;
        end
    end

    always @(posedge clk) begin
        if (underrun) begin
            ur_cnt = ur_cnt + 1;
            if (ur_prev) ur_long = ur_long + 1;
        end
        ur_prev = underrun;
        bsync_m <= {bsync_m[1:0], bclk};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame16();
        int f = frames16;
        int n = 0;
        while (frames16 == f && n < LIM) begin @(posedge clk); n++; end
        if (n >= LIM) begin
            errors++;
            $display("FAIL wait_frame16 timeout observed=%0d cycles required<%0d", n, LIM);
        end
    endtask

    task automatic wait_frame24();
        int f = frames24;
        int n = 0;
        while (frames24 == f && n < LIM) begin @(posedge clk); n++; end
        if (n >= LIM) begin
            errors++;
            $display("FAIL wait_frame24 timeout observed=%0d cycles required<%0d", n, LIM);
        end
    endtask

    task automatic wait_left_start();
        wait_frame16();
        repeat (20) @(posedge clk);
    endtask

    task automatic push16(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        @(negedge clk);
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        while (!sample_ready && n < LIM) begin @(negedge clk); n++; end
        @(negedge clk);
        sample_valid = 1'b0;
        if (n >= LIM) begin
            errors++;
            $display("FAIL push16 timeout observed=%0d cycles required<%0d", n, LIM);
        end
    endtask

    // Hold valid for exactly the clk whose edge performs the frame-start pop.
    task automatic push_at_frame_start(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        @(negedge clk);
        while (!(bsync_m[2] && !bsync_m[1] && lrck16 && idx16 == 0) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (n >= LIM) begin
            errors++;
            $display("FAIL push_at_frame_start timeout observed=%0d cycles required<%0d", n, LIM);
        end
    endtask

    initial begin
        int n;

        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_ready", 64'(sample_ready), 64'd1);
        chk("rst_dacdat", 64'(dacdat), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        reset = 1'b0;

        // Empty FIFO from reset: zero frames, one single-clk pulse per frame
        repeat (3) wait_frame16();
        ur_cnt  = 0;
        ur_long = 0;
        wait_frame16();
        chk("empty_frame_data", 64'(cap16), 64'h0);
        chk("empty_frame_ur_cnt", 64'(ur_cnt), 64'd1);
        chk("ur_pulse_width", 64'(ur_long), 64'd0);

        // Single frame
        ur_cnt = 0;
        push16(16'hA5C3, 16'h0F0F);
        chk("single_level_pre", 64'(fifo_level), 64'd1);
        wait_frame16();
        chk("single_frame", 64'(cap16), 64'hA5C3_0F0F);
        chk("single_level_post", 64'(fifo_level), 64'd0);
        chk("single_no_ur", 64'(ur_cnt), 64'd0);

        // Fill and back-pressure
        wait_left_start();
        push16(16'h0001, 16'h8000);
        push16(16'h7FFE, 16'hC001);
        push16(16'h3C3C, 16'hF00D);
        push16(16'hDEAD, 16'hBEEF);
        @(negedge clk);
        chk("fill_level", 64'(fifo_level), 64'd4);
        chk("fill_ready_low", 64'(sample_ready), 64'd0);
        push16(16'h1234, 16'h5678);
        chk("fill_level_after_5th", 64'(fifo_level), 64'd4);
        wait_frame16(); chk("fill_f1", 64'(cap16), 64'h0001_8000);
        wait_frame16(); chk("fill_f2", 64'(cap16), 64'h7FFE_C001);
        wait_frame16(); chk("fill_f3", 64'(cap16), 64'h3C3C_F00D);
        wait_frame16(); chk("fill_f4", 64'(cap16), 64'hDEAD_BEEF);
        wait_frame16(); chk("fill_f5", 64'(cap16), 64'h1234_5678);

        // Underrun after the queue drains
        ur_cnt  = 0;
        ur_long = 0;
        wait_frame16();
        chk("underrun_frame", 64'(cap16), 64'(UNDER_EXP));
        chk("underrun_cnt", 64'(ur_cnt), 64'd1);
        chk("underrun_width", 64'(ur_long), 64'd0);

        // Simultaneous push and pop at level 2
        wait_left_start();
        push16(16'hCAFE, 16'hF00D);
        push16(16'h0F0F, 16'hF0F0);
        chk("simul_level_pre", 64'(fifo_level), 64'd2);
        push_at_frame_start(16'h5A5A, 16'hA5A5);
        chk("simul_level_post", 64'(fifo_level), 64'd2);
        wait_frame16(); chk("simul_f1", 64'(cap16), 64'hCAFE_F00D);
        wait_frame16(); chk("simul_f2", 64'(cap16), 64'h0F0F_F0F0);
        wait_frame16(); chk("simul_f3", 64'(cap16), 64'h5A5A_A5A5);

        // Reset mid-left-slot after 7 bits
        push16(16'hFFFF, 16'hFFFF);
        push16(16'h1111, 16'h2222);
        n = 0;
        do begin @(posedge bclk); n++; end while (idx16 != 6 && n < 64);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_dacdat", 64'(dacdat), 64'd0);
        chk("midrst_level", 64'(fifo_level), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_frame16();
        chk("midrst_partial", 64'(cap16), 64'hFE00_0000);
        push16(16'h8001, 16'h4002);
        wait_frame16();
        chk("midrst_next_frame", 64'(cap16), 64'h8001_4002);

        // 24-bit slots carrying 16 data bits
        wait_frame24();
        @(negedge clk);
        left24  = 16'hBEEF;
        right24 = 16'h1357;
        chk("slot24_ready", 64'(ready24), 64'd1);
        valid24 = 1'b1;
        @(negedge clk);
        valid24 = 1'b0;
        chk("slot24_level", 64'(level24), 64'd1);
        wait_frame24();
        chk("slot24_frame", 64'(cap24), 64'hBEEF_0013_5700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
